// File: rtl/button_evt_pkg.sv
// Shared types and default timing for the button event generator.
package button_evt_pkg;

    // FSM encoding: two bits cover idle, short-hold, auto-repeat and frozen long-hold.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_LONGHELD = 2'd3
    } btn_state_e;

    // Default timing constants in clock cycles.
    localparam int unsigned LONG_CYCLES_DEF   = 12_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF = 2_500_000;
    localparam int unsigned CNT_W_DEF         = 24;
    localparam int unsigned RCOUNT_W          = 8;

endpackage

// File: rtl/button_event_gen.sv
// Converts a debounced, clk-synchronous button level into single-cycle UI events:
// press, release, click (short press), long-press and auto-repeat, plus a held flag
// and a saturating per-hold repeat count. All outputs are registered.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   btn_level     debounced button level
//   press_pulse   1-cycle pulse on accepted press
//   release_pulse 1-cycle pulse on release of an accepted press
//   click_pulse   1-cycle pulse on release before the long-press threshold
//   long_pulse    1-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse  1-cycle pulse every REPEAT_CYCLES after long_pulse (REPEAT_EN=1)
//   held          high while the FSM is not idle
//   repeat_count  repeats in the current hold, saturating at 255
module button_event_gen
    import button_evt_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned CNT_W         = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_level,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic                click_pulse,
    output logic                long_pulse,
    output logic                repeat_pulse,
    output logic                held,
    output logic [RCOUNT_W-1:0] repeat_count
);

    localparam logic [CNT_W-1:0]    LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0]    REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [RCOUNT_W-1:0] RCOUNT_MAX  = '1;

    btn_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RCOUNT_W-1:0] rcount_q, rcount_d;
    logic                btn_q;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                click_q, click_d;
    logic                long_q, long_d;
    logic                repeat_q, repeat_d;
    logic                held_q, held_d;
    logic                rise, fall;

    // Edge detect against the previous level; btn_q resets high so a button held
    // through reset must be released before it can register a press.
    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    // Next-state and event logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcount_d  = rcount_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d  = ST_PRESSED;
                    cnt_d    = '0;
                    rcount_d = '0;
                    press_d  = 1'b1;
                end
            end
            ST_PRESSED: begin
                // A release on the threshold cycle wins: it is still a click.
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = REPEAT_EN ? ST_REPEAT : ST_LONGHELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                    if (rcount_q != RCOUNT_MAX) begin
                        rcount_d = rcount_q + RCOUNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LONGHELD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rcount_q  <= '0;
            btn_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rcount_q  <= rcount_d;
            btn_q     <= btn_level;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign repeat_count  = rcount_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: instance a auto-repeats, instance b does not.
module tb_button_event_gen;

    logic       clk;
    logic       rst;
    logic       btn_level;

    logic       a_press, a_release, a_click, a_long, a_repeat, a_held;
    logic [7:0] a_rcount;
    logic       b_press, b_release, b_click, b_long, b_repeat, b_held;
    logic [7:0] b_rcount;

    int tests_run;
    int tests_failed;
    int cyc;

    // Event log for instance a
    int a_press_n, a_press_at, a_rel_n, a_rel_at, a_click_n, a_click_at;
    int a_long_n, a_long_at, a_rep_n, a_multi_n;
    int a_rep_at[8];
    // Event log for instance b
    int b_press_n, b_press_at, b_rel_n, b_click_n, b_long_n, b_long_at, b_rep_n;

    button_event_gen #(
        .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1), .CNT_W(4)
    ) u_dut_a (
        .clk(clk), .rst(rst), .btn_level(btn_level),
        .press_pulse(a_press), .release_pulse(a_release), .click_pulse(a_click),
        .long_pulse(a_long), .repeat_pulse(a_repeat), .held(a_held),
        .repeat_count(a_rcount)
    );

    button_event_gen #(
        .LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b0), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .btn_level(btn_level),
        .press_pulse(b_press), .release_pulse(b_release), .click_pulse(b_click),
        .long_pulse(b_long), .repeat_pulse(b_repeat), .held(b_held),
        .repeat_count(b_rcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        a_press_n = 0; a_press_at = -1; a_rel_n = 0; a_rel_at = -1;
        a_click_n = 0; a_click_at = -1; a_long_n = 0; a_long_at = -1;
        a_rep_n = 0; a_multi_n = 0;
        for (int i = 0; i < 8; i++) a_rep_at[i] = -1;
        b_press_n = 0; b_press_at = -1; b_rel_n = 0; b_click_n = 0;
        b_long_n = 0; b_long_at = -1; b_rep_n = 0;
    endtask

    // Advance one clock edge, then sample and log outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (a_press)   begin a_press_n++; a_press_at = cyc; end
        if (a_release) begin a_rel_n++;   a_rel_at   = cyc; end
        if (a_click)   begin a_click_n++; a_click_at = cyc; end
        if (a_long)    begin a_long_n++;  a_long_at  = cyc; end
        if (a_repeat) begin
            if (a_rep_n < 8) a_rep_at[a_rep_n] = cyc;
            a_rep_n++;
        end
        if (int'(a_press) + int'(a_long) + int'(a_repeat) > 1) a_multi_n++;
        if (b_press)   begin b_press_n++; b_press_at = cyc; end
        if (b_release) b_rel_n++;
        if (b_click)   b_click_n++;
        if (b_long)    begin b_long_n++;  b_long_at  = cyc; end
        if (b_repeat)  b_rep_n++;
    endtask

    task automatic step(input logic lvl);
        btn_level = lvl;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b1;
        btn_level    = 1'b1;
        clear_log();

        // Reset state
        tick();
        tick();
        check("rst_held", 32'(a_held), 0);
        check("rst_press", 32'(a_press), 0);
        check("rst_rcount", 32'(a_rcount), 0);
        rst = 1'b0;

        // 1: button held through reset is ignored until released and pressed again
        for (int i = 0; i < 4; i++) step(1'b1);
        check("t1_no_press", 32'(a_press_n), 0);
        check("t1_idle", 32'(a_held), 0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        check("t1_press_now", 32'(a_press), 1);
        check("t1_held", 32'(a_held), 1);

        // 2: short press -> click, no long
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("t2_release", 32'(a_rel_n), 1);
        check("t2_click", 32'(a_click_n), 1);
        check("t2_coincide", 32'(a_click_at - a_rel_at), 0);
        check("t2_rel_lat", 32'(a_rel_at - a_press_at), 3);
        check("t2_held_low", 32'(a_held), 0);
        for (int i = 0; i < 10; i++) step(1'b0);
        check("t2_no_long", 32'(a_long_n), 0);
        check("t1_press_once", 32'(a_press_n), 1);

        // 3: long hold with auto-repeat, released at press+23
        clear_log();
        step(1'b1);
        for (int i = 0; i < 22; i++) step(1'b1);
        check("t3_held", 32'(a_held), 1);
        check("t3_rcount", 32'(a_rcount), 3);
        step(1'b0);
        check("t3_long_n", 32'(a_long_n), 1);
        check("t3_long_lat", 32'(a_long_at - a_press_at), 8);
        check("t3_rep_n", 32'(a_rep_n), 3);
        check("t3_rep0", 32'(a_rep_at[0] - a_press_at), 12);
        check("t3_rep1", 32'(a_rep_at[1] - a_press_at), 16);
        check("t3_rep2", 32'(a_rep_at[2] - a_press_at), 20);
        check("t3_release", 32'(a_rel_n), 1);
        check("t3_no_click", 32'(a_click_n), 0);
        check("t3_held_low", 32'(a_held), 0);
        step(1'b0);
        step(1'b0);
        check("t3_rcount_kept", 32'(a_rcount), 3);
        check("t3_one_hot", 32'(a_multi_n), 0);

        // 4: release lands on the long-threshold cycle
        clear_log();
        step(1'b1);
        for (int i = 0; i < 7; i++) step(1'b1);
        step(1'b0);
        check("t4_release", 32'(a_rel_at - a_press_at), 8);
        check("t4_click", 32'(a_click_at - a_press_at), 8);
        check("t4_held_low", 32'(a_held), 0);
        for (int i = 0; i < 4; i++) step(1'b0);
        check("t4_no_long", 32'(a_long_n), 0);
        check("t4_no_long_b", 32'(b_long_n), 0);
        check("t4_rcount_clr", 32'(a_rcount), 0);

        // 5: async reset during a repeat_pulse cycle
        clear_log();
        step(1'b1);
        for (int i = 0; i < 12; i++) step(1'b1);
        check("t5_rep_before", 32'(a_repeat), 1);
        check("t5_rcount_before", 32'(a_rcount), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_held_async", 32'(a_held), 0);
        check("t5_rep_async", 32'(a_repeat), 0);
        check("t5_rcount_async", 32'(a_rcount), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        check("t5_no_release", 32'(a_rel_n), 0);
        check("t5_no_repress", 32'(a_press_n), 1);

        // 6: REPEAT_EN=0 instance, hold 30 cycles
        clear_log();
        step(1'b1);
        for (int i = 0; i < 30; i++) step(1'b1);
        check("t6_long_n", 32'(b_long_n), 1);
        check("t6_long_lat", 32'(b_long_at - b_press_at), 8);
        check("t6_no_repeat", 32'(b_rep_n), 0);
        check("t6_rcount", 32'(b_rcount), 0);
        check("t6_held", 32'(b_held), 1);
        step(1'b0);
        check("t6_release", 32'(b_rel_n), 1);
        check("t6_no_click", 32'(b_click_n), 0);
        check("t6_a_rep_n", 32'(a_rep_n), 5);
        check("t6_a_one_hot", 32'(a_multi_n), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
